// File: rtl/bcd_entry_ctrl.sv
// bcd_entry_ctrl: debounced BCD keypad entry committing alternately into two operand registers
module bcd_entry_ctrl #(
  parameter int DIGITS = 3,
  parameter int SIGNED = 1,
  parameter int DEBOUNCE = 500000,
  parameter int BLINK_DIV = 25000000,
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_enter,
  input  logic              key_back,
  input  logic [3:0]        digit_in,
  input  logic              sign_in,
  output logic [4*DIGITS-1:0] val_a,
  output logic              neg_a,
  output logic [4*DIGITS-1:0] val_b,
  output logic              neg_b,
  output logic              target,
  output logic [CW-1:0]     cursor,
  output logic [4*DIGITS-1:0] disp,
  output logic              disp_neg,
  output logic              done,
  output logic              err
);
  localparam int W = 4 * DIGITS;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [DW-1:0] DB_END = DW'(DEBOUNCE - 1);
  localparam logic [BW-1:0] BL_END = BW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
  logic [1:0] s1_q, s2_q, db_q, db_d, p_q, p_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];
  logic [BW-1:0] bc_q, bc_d;
  logic blink_q, blink_d;
  logic [W-1:0] sh_q, sh_d, va_q, va_d, vb_q, vb_d;
  logic na_q, na_d, nb_q, nb_d, tgt_q, tgt_d, done_q, done_d, err_q, err_d;
  logic [CW-1:0] cur_q, cur_d;
  logic p_enter, p_back, p_any;
  assign p_enter = p_q[0];
  assign p_back = p_q[1];
  assign p_any = p_enter | p_back;
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = (s2_q[k] == db_q[k] || cnt_q[k] == DB_END) ? '0 : cnt_q[k] + 1'b1;
      db_d[k] = (s2_q[k] != db_q[k] && cnt_q[k] == DB_END) ? s2_q[k] : db_q[k];
      p_d[k] = db_d[k] & ~db_q[k];
    end
  end
  always_comb begin
    bc_d = (p_any || bc_q == BL_END) ? '0 : bc_q + 1'b1;
    blink_d = p_any ? 1'b1 : (bc_q == BL_END) ? ~blink_q : blink_q;
  end
  always_comb begin
    sh_d = sh_q;
    cur_d = cur_q;
    tgt_d = tgt_q;
    va_d = va_q;
    vb_d = vb_q;
    na_d = na_q;
    nb_d = nb_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (p_back) begin
      if (cur_q != '0) begin
        cur_d = cur_q - 1'b1;
        sh_d[4*(cur_q - 1'b1) +: 4] = 4'd0;
      end
    end else if (p_enter) begin
      if (digit_in > 4'd9) err_d = 1'b1;
      else begin
        sh_d[4*cur_q +: 4] = digit_in;
        if (cur_q != LAST) cur_d = cur_q + 1'b1;
        else begin
          if (tgt_q) begin
            vb_d = sh_d;
            nb_d = sign_in & (SIGNED != 0);
          end else begin
            va_d = sh_d;
            na_d = sign_in & (SIGNED != 0);
          end
          sh_d = '0;
          cur_d = '0;
          tgt_d = ~tgt_q;
          done_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      p_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      bc_q <= '0;
      blink_q <= 1'b1;
      sh_q <= '0;
      va_q <= '0;
      vb_q <= '0;
      na_q <= 1'b0;
      nb_q <= 1'b0;
      tgt_q <= 1'b0;
      cur_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s1_q <= {key_back, key_enter};
      s2_q <= s1_q;
      db_q <= db_d;
      p_q <= p_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      bc_q <= bc_d;
      blink_q <= blink_d;
      sh_q <= sh_d;
      va_q <= va_d;
      vb_q <= vb_d;
      na_q <= na_d;
      nb_q <= nb_d;
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  for (genvar i = 0; i < DIGITS; i++) begin : g_disp
    assign disp[4*i +: 4] = (CW'(i) < cur_q) ? sh_q[4*i +: 4] :
                            (CW'(i) == cur_q && blink_q && digit_in <= 4'd9) ? digit_in : 4'hF;
  end
  assign disp_neg = sign_in & (SIGNED != 0);
  assign val_a = va_q;
  assign val_b = vb_q;
  assign neg_a = na_q;
  assign neg_b = nb_q;
  assign target = tgt_q;
  assign cursor = cur_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_bcd_entry_ctrl.sv
// tb_bcd_entry_ctrl: table, hand-written and random key presses against an event-level entry model
module tb_bcd_entry_ctrl;
  localparam int DG = 3;
  logic clk = 0, rst = 0, key_enter = 0, key_back = 0, sign_in = 0;
  logic [3:0] digit_in = 0;
  logic [11:0] s_val_a, s_val_b, s_disp, u_val_a, u_val_b, u_disp;
  logic s_neg_a, s_neg_b, s_target, s_disp_neg, s_done, s_err;
  logic u_neg_a, u_neg_b, u_target, u_disp_neg, u_done, u_err;
  logic [1:0] s_cursor, u_cursor;
  int tests = 0, fails = 0, done_cnt = 0, err_cnt = 0;
  logic [3:0] m_sh [DG];
  int m_cur = 0;
  bit m_tgt = 0, m_na = 0, m_nb = 0, got_done, got_err;
  logic [11:0] m_va = 0, m_vb = 0;
  typedef struct {
    bit e;
    bit b;
    logic [3:0] d;
    bit s;
    int cur;
    bit dn;
    bit er;
    logic [11:0] va;
    logic [11:0] vb;
  } vec_t;
  vec_t tbl [12];
  bcd_entry_ctrl #(.DIGITS(DG), .SIGNED(1), .DEBOUNCE(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst), .key_enter(key_enter), .key_back(key_back), .digit_in(digit_in),
    .sign_in(sign_in), .val_a(s_val_a), .neg_a(s_neg_a), .val_b(s_val_b), .neg_b(s_neg_b),
    .target(s_target), .cursor(s_cursor), .disp(s_disp), .disp_neg(s_disp_neg),
    .done(s_done), .err(s_err));
  bcd_entry_ctrl #(.DIGITS(DG), .SIGNED(0), .DEBOUNCE(4), .BLINK_DIV(8)) dut0 (
    .clk(clk), .rst(rst), .key_enter(key_enter), .key_back(key_back), .digit_in(digit_in),
    .sign_in(sign_in), .val_a(u_val_a), .neg_a(u_neg_a), .val_b(u_val_b), .neg_b(u_neg_b),
    .target(u_target), .cursor(u_cursor), .disp(u_disp), .disp_neg(u_disp_neg),
    .done(u_done), .err(u_err));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (s_done) done_cnt++;
    if (s_err) err_cnt++;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < DG; i++) m_sh[i] = 0;
    m_cur = 0;
    m_tgt = 0;
    m_na = 0;
    m_nb = 0;
    m_va = 0;
    m_vb = 0;
  endtask
  task automatic model_ev(input bit e, input bit b, input logic [3:0] d, input bit s,
                          output bit md, output bit me);
    logic [11:0] v;
    md = 0;
    me = 0;
    if (b) begin
      if (m_cur > 0) begin
        m_cur--;
        m_sh[m_cur] = 0;
      end
    end else if (e) begin
      if (d > 9) me = 1;
      else begin
        m_sh[m_cur] = d;
        m_cur++;
        if (m_cur == DG) begin
          v = 0;
          for (int i = 0; i < DG; i++) v = v | (12'(m_sh[i]) << (4 * i));
          if (m_tgt) begin
            m_vb = v;
            m_nb = s;
          end else begin
            m_va = v;
            m_na = s;
          end
          m_tgt = !m_tgt;
          for (int i = 0; i < DG; i++) m_sh[i] = 0;
          m_cur = 0;
          md = 1;
        end
      end
    end
  endtask
  task automatic check_all(input string t);
    logic [11:0] ed;
    ed = 12'hFFF;
    for (int i = 0; i < DG; i++)
      if (i < m_cur) ed[4*i +: 4] = m_sh[i];
      else if (i == m_cur && digit_in <= 9) ed[4*i +: 4] = digit_in;
    chk({t, " cursor"}, s_cursor, m_cur);
    chk({t, " target"}, s_target, m_tgt);
    chk({t, " val_a"}, s_val_a, m_va);
    chk({t, " val_b"}, s_val_b, m_vb);
    chk({t, " neg_a"}, s_neg_a, m_na);
    chk({t, " neg_b"}, s_neg_b, m_nb);
    chk({t, " disp"}, s_disp, ed);
    chk({t, " disp_neg"}, s_disp_neg, sign_in);
    chk({t, " u_cursor"}, u_cursor, m_cur);
    chk({t, " u_target"}, u_target, m_tgt);
    chk({t, " u_vals"}, {u_val_b, u_val_a}, {m_vb, m_va});
    chk({t, " u_negs"}, {u_neg_b, u_neg_a}, 0);
    chk({t, " u_disp"}, u_disp, ed);
    chk({t, " u_disp_neg"}, u_disp_neg, 0);
  endtask
  task automatic press(input bit e, input bit b, input logic [3:0] d, input bit s,
                       input int hold, input string t);
    int pre;
    bit md, me;
    pre = m_cur;
    @(negedge clk);
    key_enter = e;
    key_back = b;
    digit_in = d;
    sign_in = s;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk({t, " early cursor"}, s_cursor, pre);
    chk({t, " early done/err"}, {s_done, s_err}, 0);
    model_ev(e, b, d, s, md, me);
    @(negedge clk);
    got_done = s_done;
    got_err = s_err;
    check_all(t);
    chk({t, " done"}, s_done, md);
    chk({t, " err"}, s_err, me);
    chk({t, " u_done/err"}, {u_done, u_err}, {md, me});
    @(negedge clk);
    chk({t, " pulse end"}, {s_done, s_err}, 0);
    repeat (hold - 8) @(negedge clk);
    key_enter = 0;
    key_back = 0;
    repeat (8) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    key_enter = 0;
    key_back = 0;
    #1;
    model_reset();
    check_all("in_reset");
    repeat (2) @(negedge clk);
    rst = 1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int dc, ec, r;
    tbl[0] = '{1, 0, 4'd3, 0, 1, 0, 0, 12'h000, 12'h000};
    tbl[1] = '{1, 0, 4'd2, 0, 2, 0, 0, 12'h000, 12'h000};
    tbl[2] = '{1, 0, 4'd1, 1, 0, 1, 0, 12'h123, 12'h000};
    tbl[3] = '{1, 0, 4'hC, 0, 0, 0, 1, 12'h123, 12'h000};
    tbl[4] = '{1, 0, 4'd5, 0, 1, 0, 0, 12'h123, 12'h000};
    tbl[5] = '{0, 1, 4'd5, 0, 0, 0, 0, 12'h123, 12'h000};
    tbl[6] = '{0, 1, 4'd5, 0, 0, 0, 0, 12'h123, 12'h000};
    tbl[7] = '{1, 0, 4'd9, 0, 1, 0, 0, 12'h123, 12'h000};
    tbl[8] = '{1, 0, 4'd0, 0, 2, 0, 0, 12'h123, 12'h000};
    tbl[9] = '{1, 1, 4'd4, 0, 1, 0, 0, 12'h123, 12'h000};
    tbl[10] = '{1, 0, 4'd8, 0, 2, 0, 0, 12'h123, 12'h000};
    tbl[11] = '{1, 0, 4'd6, 0, 0, 1, 0, 12'h123, 12'h689};
    model_reset();
    digit_in = 7;
    do_reset();
    @(negedge clk);
    check_all("reset");
    chk("reset disp", s_disp, 12'hFF7);
    chk("reset done/err", {s_done, s_err}, 0);
    repeat (6) @(negedge clk);
    chk("blink on edge7", s_disp, 12'hFF7);
    @(negedge clk);
    chk("blink off edge8", s_disp, 12'hFFF);
    repeat (8) @(negedge clk);
    chk("blink on edge16", s_disp, 12'hFF7);
    for (int i = 0; i < 12; i++) begin
      press(tbl[i].e, tbl[i].b, tbl[i].d, tbl[i].s, 8, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d cursor", i), s_cursor, tbl[i].cur);
      chk($sformatf("tbl%0d done/err", i), {got_done, got_err}, {tbl[i].dn, tbl[i].er});
      chk($sformatf("tbl%0d vals", i), {s_val_b, s_val_a}, {tbl[i].vb, tbl[i].va});
    end
    dc = done_cnt;
    ec = err_cnt;
    @(negedge clk);
    key_enter = 1;
    digit_in = 2;
    repeat (3) @(negedge clk);
    key_enter = 0;
    repeat (12) @(negedge clk);
    chk("glitch cursor", s_cursor, 0);
    chk("glitch pulses", {done_cnt, err_cnt}, {dc, ec});
    press(1, 0, 4'd4, 0, 40, "hold");
    chk("hold single event", s_cursor, 1);
    press(0, 1, 4'd4, 0, 8, "hold_back");
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      press(r < 8 || r == 9, r >= 8, 4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
            $urandom_range(8, 14), $sformatf("rnd%0d", i));
    end
    do_reset();
    press(1, 0, 4'd1, 0, 8, "mid1");
    press(1, 0, 4'd2, 0, 8, "mid2");
    chk("mid cursor", s_cursor, 2);
    do_reset();
    @(negedge clk);
    check_all("after_mid_reset");
    chk("mid reset ops", {s_val_a, s_val_b, s_target}, 0);
    press(1, 0, 4'd7, 0, 8, "sa0");
    press(1, 0, 4'd0, 0, 8, "sa1");
    press(1, 0, 4'd4, 0, 8, "sa2");
    press(1, 0, 4'd5, 1, 8, "sb0");
    press(1, 0, 4'd6, 1, 8, "sb1");
    press(1, 0, 4'd9, 1, 8, "sb2");
    chk("signed0 neg_b", u_neg_b, 0);
    chk("signed0 disp_neg", u_disp_neg, 0);
    chk("signed1 neg_b", s_neg_b, 1);
    chk("signed val_b", s_val_b, 12'h965);
    chk("signed val_a", s_val_a, 12'h407);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
